// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store path and an
// external requester; one access per cycle, read data returned one cycle after grant.
//
// rd_owner  | meaning
// ----------+--------------------------------------------------
// OWN_NONE  | no read issued last cycle, no return pending
// OWN_CPU   | CPU read issued last cycle, mem_dout belongs to CPU
// OWN_EXT   | EXT read issued last cycle, mem_dout belongs to EXT
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 16,
    parameter int ARB_MODE     = 0,
    parameter int EXT_MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  RESET_N,
    input  logic                  cpu_req,
    input  logic                  cpu_w,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    input  logic                  ext_req,
    input  logic                  ext_w,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic                  ext_gnt,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    output logic                  ext_rvalid,
    output logic                  mem_en,
    output logic                  mem_r_w,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int WCW = $clog2(EXT_MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(EXT_MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    owner_t                rd_owner, rd_owner_nxt;
    logic                  last_gnt_ext;
    logic [WCW-1:0]        wait_cnt;
    logic                  ext_pref, ext_win, cpu_win;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, ext_rdata_q;

    // ext_pref only matters on a contested cycle
    always_comb begin
        ext_pref = (ARB_MODE == 0) ? !last_gnt_ext : (wait_cnt == WAIT_MAX);
        ext_win  = ext_req & (!cpu_req | ext_pref);
        cpu_win  = cpu_req & !ext_win;
    end

    always_comb begin
        mem_en       = 1'b0;
        mem_r_w      = 1'b0;
        mem_addr     = '0;
        mem_din      = '0;
        rd_owner_nxt = OWN_NONE;
        if (cpu_win) begin
            mem_en       = 1'b1;
            mem_r_w      = cpu_w;
            mem_addr     = cpu_addr;
            mem_din      = cpu_wdata;
            rd_owner_nxt = cpu_w ? OWN_NONE : OWN_CPU;
        end else if (ext_win) begin
            mem_en       = 1'b1;
            mem_r_w      = ext_w;
            mem_addr     = ext_addr;
            mem_din      = ext_wdata;
            rd_owner_nxt = ext_w ? OWN_NONE : OWN_EXT;
        end
    end

    assign cpu_stall = cpu_req & !cpu_win;
    assign ext_gnt   = ext_win;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            last_gnt_ext <= 1'b1;
            wait_cnt     <= '0;
            rd_owner     <= OWN_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
            if (cpu_win) begin
                last_gnt_ext <= 1'b0;
            end else if (ext_win) begin
                last_gnt_ext <= 1'b1;
            end
            if (!ext_req || ext_win) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // mem_dout is already a registered memory output; the hold registers keep
    // the last returned word visible after the valid pulse.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            if (rd_owner == OWN_CPU) begin
                cpu_rdata_q <= mem_dout;
            end
            if (rd_owner == OWN_EXT) begin
                ext_rdata_q <= mem_dout;
            end
        end
    end

    assign cpu_rvalid = (rd_owner == OWN_CPU);
    assign ext_rvalid = (rd_owner == OWN_EXT);
    assign cpu_rdata  = cpu_rvalid ? mem_dout : cpu_rdata_q;
    assign ext_rdata  = ext_rvalid ? mem_dout : ext_rdata_q;

endmodule
